// File: rtl/cfi_log_queue.sv
// cfi_log_queue: consumer end of the CFI log interface.
// Buffers flagged per-commit-port CFI logs in commit order and serialises
// each one as three 64-bit beats on a valid/ready stream to the CFI checker.

package cfi_log_pkg;
  // Virtual address width of the core; beats zero-fill the bits above it.
  localparam int VLEN = 39;

  typedef struct packed {
    logic branch;
    logic jump;
    logic call;
    logic ret;
  } cfi_flags_t;

  typedef struct packed {
    cfi_flags_t        flags;
    logic [VLEN-1:0]   addr_pc;
    logic [VLEN-1:0]   addr_npc;
    logic [VLEN-1:0]   addr_target;
  } cfi_log_t;
endpackage

module cfi_log_queue
  import cfi_log_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 16,
  parameter int DROP_CNT_W      = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  cfi_log_t [NR_COMMIT_PORTS-1:0]     log_i,
  input  logic [NR_COMMIT_PORTS-1:0]         cfi_i,
  output logic                               stall_o,
  output logic [63:0]                        beat_data_o,
  output logic                               beat_valid_o,
  output logic                               beat_last_o,
  input  logic                               beat_ready_i,
  output logic                               overflow_o,
  input  logic                               clear_overflow_i,
  output logic [DROP_CNT_W-1:0]              drop_cnt_o,
  output logic [$clog2(DEPTH):0]             level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int NW    = $clog2(NR_COMMIT_PORTS + 1);

  // Elaboration-time sanity checks on the configuration.
  generate
    if (VLEN > 60) begin : g_vlen_chk
      $error("cfi_log_queue: VLEN must be <= 60 to fit beside the flags");
    end
    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2 * NR_COMMIT_PORTS)) begin : g_depth_chk
      $error("cfi_log_queue: DEPTH must be a power of 2 and >= 2*NR_COMMIT_PORTS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

  cfi_log_t               r_mem [DEPTH];
  cfi_log_t               r_entry;
  state_t                 r_state;
  logic [PTR_W-1:0]       r_wrptr;
  logic [PTR_W-1:0]       r_rdptr;
  logic [63:0]            r_beat_data;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_overflow;
  logic [DROP_CNT_W-1:0]  r_drop_cnt;
  logic                   r_stall;

  logic [PTR_W-1:0]       w_level;
  logic [PTR_W-1:0]       w_free;
  logic [PTR_W-1:0]       w_level_next;
  logic [PTR_W-1:0]       w_free_next;
  logic [NW-1:0]          w_n;
  logic [AW-1:0]          w_wr_addr [NR_COMMIT_PORTS];
  logic                   w_push_ok;
  logic                   w_drop;
  logic                   w_hs;
  logic                   w_pop;
  logic [DROP_CNT_W-1:0]  w_drop_base;
  logic [DROP_CNT_W:0]    w_drop_sum;
  cfi_log_t               w_head;
  cfi_log_t               w_next_head;

  // First beat: flags in the top nibble, PC zero-extended in the low bits.
  function automatic logic [63:0] beat0(input cfi_log_t e);
    logic [63:0] b;
    b             = '0;
    b[63:60]      = e.flags;
    b[VLEN-1:0]   = e.addr_pc;
    return b;
  endfunction

  function automatic logic [63:0] zext(input logic [VLEN-1:0] a);
    return 64'(a);
  endfunction

  assign w_level      = r_wrptr - r_rdptr;
  assign w_free       = PTR_W'(DEPTH) - w_level;
  // A push is all-or-nothing and uses the free space seen at cycle start.
  assign w_push_ok    = PTR_W'(w_n) <= w_free;
  assign w_drop       = (w_n != '0) && !w_push_ok;
  assign w_hs         = r_valid & beat_ready_i;
  assign w_pop        = w_hs && (r_state == B2);
  assign w_level_next = w_level + (w_push_ok ? PTR_W'(w_n) : '0) - PTR_W'(w_pop);
  assign w_free_next  = PTR_W'(DEPTH) - w_level_next;
  assign w_head       = r_mem[r_rdptr[AW-1:0]];
  assign w_next_head  = r_mem[r_rdptr[AW-1:0] + AW'(1)];
  assign w_drop_base  = clear_overflow_i ? '0 : r_drop_cnt;
  assign w_drop_sum   = {1'b0, w_drop_base} + (DROP_CNT_W + 1)'(w_n);

  // Count flagged ports and compact them onto consecutive write slots, port 0 first.
  always_comb begin : p_compact
    logic [AW-1:0] v_off;
    v_off = '0;
    w_n   = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      w_wr_addr[p] = r_wrptr[AW-1:0] + v_off;
      v_off        = v_off + AW'(cfi_i[p]);
      w_n          = w_n + NW'(cfi_i[p]);
    end
  end

  // Storage array: write-only here, read through the serialiser's entry register.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (w_push_ok && cfi_i[p]) begin
        r_mem[w_wr_addr[p]] <= log_i[p];
      end
    end
  end

  // Write/read pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrptr <= '0;
      r_rdptr <= '0;
    end else begin
      if (w_push_ok) r_wrptr <= r_wrptr + PTR_W'(w_n);
      if (w_pop)     r_rdptr <= r_rdptr + PTR_W'(1);
    end
  end

  // Sticky overflow and saturating drop count; a drop in the clear cycle wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
    end else if (clear_overflow_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // Commit stall when the space left after this cycle cannot hold a full commit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall <= 1'b0;
    end else begin
      r_stall <= w_free_next < PTR_W'(NR_COMMIT_PORTS);
    end
  end

  // Serialiser: latch the head log, emit pc/npc/target beats, pop on the last beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_entry     <= '0;
      r_beat_data <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_level != '0) begin
            r_entry     <= w_head;
            r_beat_data <= beat0(w_head);
            r_valid     <= 1'b1;
            r_last      <= 1'b0;
            r_state     <= B0;
          end
        end
        B0: begin
          if (w_hs) begin
            r_beat_data <= zext(r_entry.addr_npc);
            r_state     <= B1;
          end
        end
        B1: begin
          if (w_hs) begin
            r_beat_data <= zext(r_entry.addr_target);
            r_last      <= 1'b1;
            r_state     <= B2;
          end
        end
        B2: begin
          if (w_hs) begin
            r_last <= 1'b0;
            if (w_level > PTR_W'(1)) begin
              r_entry     <= w_next_head;
              r_beat_data <= beat0(w_next_head);
              r_state     <= B0;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall_o      = r_stall;
  assign beat_data_o  = r_beat_data;
  assign beat_valid_o = r_valid;
  assign beat_last_o  = r_last;
  assign overflow_o   = r_overflow;
  assign drop_cnt_o   = r_drop_cnt;
  assign level_o      = w_level;

endmodule
